ss_mchan_corr: RTL and testbench

Multi-channel, parametrised spread-spectrum correlator, successor to the single-channel `ss` block. It despreads one signed sample stream against NCH independently programmed LFSR PN codes in parallel. Each channel integrates over a programmable chip count. Per-channel results are serialised through an output FIFO with downstream backpressure and a channel tag. Configuration uses the existing addr/din/strobe register port, with registered readback on dout.

---
 rtl/ss_mchan_corr.sv | 149 ++++++++++++++
 tb/tb_ss_mchan_corr.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ss_mchan_corr.sv
// ss_mchan_corr: NCH-channel PN despreading correlator with a shared result FIFO.
module ss_mchan_corr #(
  parameter int SAMP_W      = 12,
  parameter int CORR_W      = 32,
  parameter int NCH         = 4,
  parameter int LFSR_W      = 16,
  parameter int OFIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  input  logic [3:0]        addr,
  input  logic              strobe,
  input  logic [SAMP_W-1:0] samp,
  input  logic              push_samp,
  input  logic              sync,
  input  logic              stop_corr,
  output logic              push_corr,
  output logic [CORR_W-1:0] corr,
  output logic [2:0]        corr_ch
);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int FW = CORR_W + 3;
  logic [NCH-1:0]    ctrl;
  logic [15:0]       int_len, len_eff;
  logic [LFSR_W-1:0] seed [NCH];
  logic [LFSR_W-1:0] taps [NCH];
  logic [LFSR_W-1:0] lfsr [NCH];
  logic [CORR_W-1:0] acc [NCH];
  logic [CORR_W-1:0] acc_nxt [NCH];
  logic [CORR_W-1:0] res [NCH];
  logic [15:0]       cnt [NCH];
  logic [NCH-1:0]    pend, done, en, clr;
  logic              overrun, any, wr, pop, full;
  logic [CORR_W-1:0] sx;
  logic [31:0]       rd;
  logic [FW-1:0]     mem [OFIFO_DEPTH];
  logic [FW-1:0]     wdat;
  logic [AW-1:0]     wp, rp;
  logic [AW:0]       count;

  assign sx      = {{(CORR_W-SAMP_W){samp[SAMP_W-1]}}, samp};
  assign len_eff = int_len == '0 ? 16'd1 : int_len;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      en[c]      = push_samp & ~sync & ctrl[c];
      acc_nxt[c] = acc[c] + (lfsr[c][0] ? sx : -sx);
      done[c]    = en[c] & (cnt[c] + 16'd1 == len_eff);
    end
  end

  // descending scan so the lowest pending channel is the one left selected
  always_comb begin
    clr  = '0;
    wdat = '0;
    any  = |pend;
    pop  = count != '0 && !stop_corr;
    full = count == (AW+1)'(OFIFO_DEPTH);
    wr   = any & (~full | pop);
    for (int c = NCH-1; c >= 0; c--)
      if (pend[c]) begin
        clr    = '0;
        clr[c] = wr;
        wdat   = {3'(c), res[c]};
      end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        lfsr[c] <= LFSR_W'(1);
        acc[c]  <= '0;
        cnt[c]  <= '0;
        res[c]  <= '0;
      end
      pend <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (sync) begin
          lfsr[c] <= seed[c];
          acc[c]  <= '0;
          cnt[c]  <= '0;
        end else if (en[c]) begin
          lfsr[c] <= (lfsr[c] >> 1) ^ (lfsr[c][0] ? taps[c] : '0);
          acc[c]  <= done[c] ? '0 : acc_nxt[c];
          cnt[c]  <= done[c] ? '0 : cnt[c] + 16'd1;
        end
        if (done[c]) res[c] <= acc_nxt[c];
      end
      pend <= sync ? '0 : done | (pend & ~clr);
    end

  always_comb begin
    rd = addr == 4'd0  ? 32'(ctrl) :
         addr == 4'd1  ? {16'd0, int_len} :
         addr == 4'd14 ? {22'd0, sync, overrun, 8'(count)} :
         addr == 4'd15 ? 32'h53534D43 : '0;
    for (int c = 0; c < NCH; c++) begin
      if (addr == 4'(2 + 2*c)) rd = 32'(seed[c]);
      if (addr == 4'(3 + 2*c)) rd = 32'(taps[c]);
    end
  end

  // a result lost only when it overwrites one the arbiter is not taking this cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl    <= '0;
      int_len <= '0;
      overrun <= 1'b0;
      dout    <= '0;
      for (int c = 0; c < NCH; c++) begin
        seed[c] <= LFSR_W'(1);
        taps[c] <= '0;
      end
    end else begin
      if (strobe && addr == 4'd0) ctrl <= din[NCH-1:0];
      if (strobe && addr == 4'd1) int_len <= din[15:0];
      for (int c = 0; c < NCH; c++) begin
        if (strobe && addr == 4'(2 + 2*c)) seed[c] <= din[LFSR_W-1:0];
        if (strobe && addr == 4'(3 + 2*c)) taps[c] <= din[LFSR_W-1:0];
      end
      overrun <= (|(done & pend & ~clr)) | (overrun & ~(strobe && addr == 4'd14 && din[8]));
      dout    <= rd;
    end

  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdat;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      push_corr <= 1'b0;
      corr      <= '0;
      corr_ch   <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) begin
        rp      <= rp + 1'b1;
        corr    <= mem[rp][CORR_W-1:0];
        corr_ch <= mem[rp][FW-1 -: 3];
      end
      push_corr <= pop;
      count     <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
endmodule

// File: tb/tb_ss_mchan_corr.sv
// tb_ss_mchan_corr: directed vectors with hand-computed correlator results.
module tb_ss_mchan_corr;
  logic        clk = 0, reset = 1;
  logic [31:0] din = 0, dout, corr, v;
  logic [3:0]  addr = 0;
  logic        strobe = 0, push_samp = 0, sync = 0, stop_corr = 0, push_corr;
  logic [11:0] samp = 0;
  logic [2:0]  corr_ch;
  int          nvec = 0, nfail = 0, cyc = 0, e0;
  logic [31:0] oq[$];
  int          cq[$], tq[$];

  ss_mchan_corr dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .addr(addr), .strobe(strobe),
    .samp(samp), .push_samp(push_samp), .sync(sync), .stop_corr(stop_corr),
    .push_corr(push_corr), .corr(corr), .corr_ch(corr_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (push_corr) begin
      oq.push_back(corr);
      cq.push_back(int'(corr_ch));
      tq.push_back(cyc);
    end

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function logic [31:0] qo(input int i);
    return i < oq.size() ? oq[i] : 32'hDEADBEEF;
  endfunction
  function int qc(input int i);
    return i < cq.size() ? cq[i] : -1;
  endfunction
  function int qt(input int i);
    return i < tq.size() ? tq[i] : -1;
  endfunction

  task idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task wreg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk) addr = a; din = d; strobe = 1;
    @(negedge clk) strobe = 0;
  endtask
  task rreg(input logic [3:0] a, output logic [31:0] r);
    @(negedge clk) addr = a;
    @(negedge clk) r = dout;
  endtask
  task pulse_sync;
    @(negedge clk) sync = 1;
    @(negedge clk) sync = 0;
  endtask
  task push(input logic [11:0] s);
    @(negedge clk) samp = s; push_samp = 1;
    @(negedge clk) push_samp = 0;
  endtask
  task cfg2;
    wreg(0, 3); wreg(1, 4); wreg(2, 1); wreg(3, 0); wreg(4, 32'hF); wreg(5, 0);
  endtask

  initial begin
    #1_000_000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    chk("rst_push", push_corr, 0);
    chk("rst_corr", corr, 0);
    chk("rst_ch", corr_ch, 0);
    chk("rst_dout", dout, 0);
    reset = 0;
    rreg(15, v); chk("id", v, 32'h53534D43);
    rreg(2, v);  chk("seed0_rst", v, 1);
    rreg(12, v); chk("unmapped", v, 0);
    wreg(15, 32'h1234); rreg(15, v); chk("id_ro", v, 32'h53534D43);
    chk("rst_nopush", oq.size(), 0);

    // basic despread: ch0 chips 1,0,0,0 ; ch1 chips 1,1,1,1
    cfg2();
    rreg(1, v); chk("intlen_rb", v, 4);
    pulse_sync(); oq.delete(); cq.delete(); tq.delete();
    repeat (4) push(12'd10);
    e0 = cyc;
    idle(6);
    chk("basic_n", oq.size(), 2);
    chk("basic_v0", qo(0), 32'hFFFFFFEC); chk("basic_c0", qc(0), 0); chk("basic_t0", qt(0), e0 + 2);
    chk("basic_v1", qo(1), 32'h28);       chk("basic_c1", qc(1), 1); chk("basic_t1", qt(1), e0 + 3);

    // negative samples with chips 1,1
    wreg(2, 32'hF); wreg(3, 0); wreg(0, 1); wreg(1, 2);
    pulse_sync(); oq.delete(); cq.delete();
    repeat (2) push(12'hFFF);
    idle(6);
    chk("neg_n", oq.size(), 1);
    chk("neg_v", qo(0), 32'hFFFFFFFE);
    chk("neg_c", qc(0), 0);

    // backpressure: constant chip 1, one result per sample
    wreg(2, 1); wreg(3, 1); wreg(0, 1); wreg(1, 1);
    pulse_sync(); oq.delete(); cq.delete(); tq.delete();
    @(negedge clk) stop_corr = 1;
    for (int i = 1; i <= 12; i++) push(12'(i));
    idle(3);
    rreg(14, v);
    chk("bp_count", v[7:0], 8);
    chk("bp_ovr", v[8], 1);
    chk("bp_stall", oq.size(), 0);
    stop_corr = 0;
    idle(15);
    chk("bp_n", oq.size(), 9);
    for (int i = 0; i < 8; i++) chk("bp_word", qo(i), 32'(i + 1));
    chk("bp_pend", qo(8), 12);
    chk("bp_b2b", qt(7) - qt(0), 7);
    wreg(14, 32'h100); rreg(14, v); chk("bp_clr", v, 0);

    // sync mid-integration, sync-level readback, sample dropped under sync
    cfg2();
    pulse_sync(); oq.delete(); cq.delete();
    push(12'd7); push(12'd7);
    @(negedge clk) sync = 1; push_samp = 1; samp = 12'd100; addr = 14;
    @(negedge clk) chk("sync_active", dout[9], 1); sync = 0; push_samp = 0;
    repeat (4) push(12'd10);
    idle(8);
    chk("sync_n", oq.size(), 2);
    chk("sync_v0", qo(0), 32'hFFFFFFEC); chk("sync_c0", qc(0), 0);
    chk("sync_v1", qo(1), 32'h28);       chk("sync_c1", qc(1), 1);

    // async reset during an output burst
    wreg(2, 1); wreg(3, 1); wreg(0, 1); wreg(1, 1);
    pulse_sync();
    @(negedge clk) stop_corr = 1;
    for (int i = 1; i <= 5; i++) push(12'(i));
    stop_corr = 0;
    @(posedge clk); #1 chk("burst_live", push_corr, 1);
    #1 reset = 1;
    #1 chk("arst_push", push_corr, 0); chk("arst_corr", corr, 0);
    @(negedge clk) reset = 0;
    oq.delete();
    rreg(14, v); chk("arst_status", v, 0);
    rreg(0, v);  chk("arst_ctrl", v, 0);
    for (int i = 1; i <= 5; i++) push(12'(i));
    idle(10);
    chk("arst_quiet", oq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
